// File: rtl/bcd16_convert_if.sv
// Handshake/data bundle between the multiplier side and the BCD converter.
// The master drives the operand and start request; the slave returns the
// packed BCD result with its busy/done status.
interface bcd16_convert_if;
  logic [15:0] BIN;
  logic        start;
  logic [19:0] BCD;
  logic        busy;
  logic        done;

  modport master (
    output BIN,
    output start,
    input  BCD,
    input  busy,
    input  done
  );

  modport slave (
    input  BIN,
    input  start,
    output BCD,
    output busy,
    output done
  );
endinterface

// File: rtl/bcd16_convert.sv
// 16-bit binary to 5-digit packed BCD converter (double-dabble).
// One bit is consumed per SHIFT cycle, so a conversion takes 16 cycles,
// followed by a single DONE cycle that carries the done pulse.
module bcd16_convert (
  input  logic             CLK,
  input  logic             RESET,
  bcd16_convert_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [15:0] shift_q,   shift_d;
  logic [19:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic [19:0] bcd_q,     bcd_d;

  logic [19:0] adjusted;
  logic [35:0] pair;
  logic [35:0] pair_sh;

  // Add 3 to a digit that would overflow past 9 once doubled.
  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Per-digit correction followed by the combined 36-bit left shift.
  always_comb begin
    adjusted = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      adjusted[i*4 +: 4] = dabble(scratch_q[i*4 +: 4]);
    end
    pair    = {adjusted, shift_q};
    pair_sh = {pair[34:0], 1'b0};
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.BIN;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = pair_sh[35:16];
        shift_d   = pair_sh[15:0];
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          bcd_d   = pair_sh[35:16];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bus.BCD  = bcd_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_bcd16_convert.sv
// Self-checking bench for bcd16_convert: directed scenarios plus randomized
// conversions compared against a decimal-arithmetic reference.
module tb_bcd16_convert;

  logic CLK = 1'b0;
  logic RESET;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [19:0] last_bcd;

  bcd16_convert_if bus ();

  bcd16_convert dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: decimal digits obtained by plain division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Caller is at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run_conv(input logic [15:0] b, input string tag);
    int unsigned lat, busy_n, hold_bad;
    logic seen;
    logic [19:0] exp;
    exp = ref_bcd(int'(b));
    bus.BIN   = b;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.BIN   = 16'($urandom);
    lat = 1; busy_n = 0; hold_bad = 0; seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_n++;
        if (bus.BCD !== last_bcd) hold_bad++;
        @(negedge CLK);
        bus.BIN = 16'($urandom);
        lat++;
      end
    end
    check({tag, "_lat"}, lat, 17);
    check({tag, "_busy"}, busy_n, 16);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_bcd"}, bus.BCD, exp);
    check({tag, "_busy_done"}, bus.busy, 1'b0);
    @(negedge CLK);
    check({tag, "_pulse"}, bus.done, 1'b0);
    last_bcd = exp;
  endtask

  initial begin
    int unsigned busy_n, dn;
    int unsigned done_at[$];

    RESET = 1'b1; bus.start = 1'b0; bus.BIN = '0;
    repeat (3) @(negedge CLK);
    check("rst_bcd", bus.BCD, 20'h00000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);

    // start coinciding with reset must be dropped
    bus.start = 1'b1; bus.BIN = 16'd55;
    @(negedge CLK);
    check("rst_start_busy", bus.busy, 1'b0);
    RESET = 1'b0; bus.start = 1'b0;
    @(negedge CLK);
    check("rst_start_idle", bus.busy, 1'b0);
    check("rst_start_done", bus.done, 1'b0);
    last_bcd = 20'h00000;

    run_conv(16'd0,     "bin0");
    run_conv(16'd20,    "bin20");
    run_conv(16'd65025, "bin65025");
    run_conv(16'd65535, "bin65535");
    run_conv(16'd9,     "bin9");
    run_conv(16'd10,    "bin10");
    run_conv(16'd9999,  "bin9999");
    run_conv(16'd10000, "bin10000");
    run_conv(16'd59999, "bin59999");
    run_conv(16'd60000, "bin60000");

    // second start and BIN change mid-conversion are ignored
    bus.BIN = 16'd1234; bus.start = 1'b1;
    busy_n = 0; dn = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        dn++;
        check("mid_bcd", bus.BCD, 20'h01234);
      end
      if (i == 1) bus.start = 1'b0;
      if (i == 5) begin bus.start = 1'b1; bus.BIN = 16'd9999; end
      if (i == 6) bus.start = 1'b0;
    end
    check("mid_dones", dn, 1);
    check("mid_busy", busy_n, 16);
    last_bcd = 20'h01234;

    // reset aborts a conversion with no done
    bus.BIN = 16'd4321; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (7) @(negedge CLK);
    check("abort_busy_pre", bus.busy, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_bcd", bus.BCD, 20'h00000);
    dn = 0;
    repeat (25) begin
      @(negedge CLK);
      if (bus.done) dn++;
    end
    check("abort_nodone", dn, 0);
    last_bcd = 20'h00000;
    run_conv(16'd4321, "after_abort");

    // start held high: one result every 18 cycles
    bus.BIN = 16'd100; bus.start = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge CLK);
      if (bus.done) begin
        done_at.push_back(i);
        check("hold_bcd", bus.BCD, 20'h00100);
      end
    end
    bus.start = 1'b0;
    check("hold_count", done_at.size(), 4);
    if (done_at.size() >= 1) check("hold_first", done_at[0], 17);
    for (int k = 1; k < done_at.size(); k++)
      check("hold_period", done_at[k] - done_at[k-1], 18);
    repeat (20) @(negedge CLK);
    last_bcd = 20'h00100;

    // randomized operands
    for (int n = 0; n < 1500; n++) begin
      run_conv(16'($urandom_range(0, 65535)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd16_convert.md
BCD16_CONVERT -- requirements
Module: bcd16_convert

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as below.
REQ-002 CLK  input  1  single clock for the whole block; all state changes occur on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 BIN  input  16  unsigned binary operand, the 16-bit product from the upstream shift-add multiplier (RESULT).
REQ-005 start  input  1  request pulse, driven from the multiplier's ready; sampled only in IDLE.
REQ-006 BCD  output  20  five packed BCD digits; [19:16] is ten-thousands and [3:0] is units; registered.
REQ-007 busy  output  1  high while a conversion is in progress (state SHIFT); registered or decoded from the state.
REQ-008 done  output  1  one-cycle pulse marking that BCD holds a new result.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-010 IDLE with start=1 on an edge SHALL capture BIN into a 16-bit shift register, clear a 20-bit digit scratch register, clear the iteration counter to 0, and go to SHIFT.
REQ-011 IDLE with start=0 SHALL hold all registers and outputs.
REQ-012 Each SHIFT cycle SHALL first add 3 to every scratch digit that is >= 5, then shift {scratch, shift register} left by one bit as a single 36-bit value, then increment the counter (double-dabble).
REQ-013 The digit add-3 SHALL be applied to all five digits independently in the same cycle; the adds never carry between digits.
REQ-014 SHIFT SHALL run exactly 16 cycles (counter 0..15); on the 16th SHIFT edge the final scratch value SHALL load into BCD and the state SHALL go to DONE.
REQ-015 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-016 Latency: with start sampled at edge N, BCD SHALL be valid and done SHALL be high in the cycle after edge N+16; the block SHALL accept a new start at edge N+18 at the earliest.
REQ-017 busy SHALL be high in SHIFT only; it SHALL be low in IDLE and DONE.
REQ-018 start SHALL be ignored in SHIFT and DONE; no queuing, and a start held through DONE is accepted at the first IDLE edge.
REQ-019 BIN SHALL be sampled only at the accepting edge; later BIN changes SHALL NOT affect the conversion in progress.
REQ-020 BCD SHALL hold its last completed value until the next conversion completes; it SHALL NOT change during SHIFT.
REQ-021 Every BCD digit SHALL be in the range 0..9 for every BIN in 0..65535; digit [19:16] SHALL never exceed 6.

Reset
REQ-022 RESET=1 at an edge SHALL force IDLE, BCD=20'h00000, done=0, busy=0, counter=0, and clear both the scratch and shift registers.
REQ-023 RESET SHALL take priority over start and over any state, including mid-SHIFT and DONE; an aborted conversion SHALL produce no done pulse.
REQ-024 A start asserted in the same edge as RESET SHALL be ignored.

Verification
REQ-025 Reset, then start with BIN=16'd0 -> done 16 cycles after the start edge, BCD=20'h00000.
REQ-026 BIN=16'd20 (5x4 product) -> BCD=20'h00020; BIN=16'd65025 (255x255) -> BCD=20'h65025; BIN=16'd65535 -> BCD=20'h65535; each with done high for exactly one cycle.
REQ-027 Start with BIN=16'd1234, pulse start again and change BIN to 16'd9999 at SHIFT cycle 5 -> exactly one done, BCD=20'h01234, busy continuously high for 16 cycles.
REQ-028 Start with BIN=16'd4321, assert RESET at SHIFT cycle 8 -> next cycle busy=0 and BCD=20'h00000, with no done pulse; a subsequent start with BIN=16'd4321 -> BCD=20'h04321.
REQ-029 Hold start high continuously with BIN=16'd100 -> done pulses every 18 cycles, BCD=20'h00100 each time; start during DONE is not accepted.
REQ-030 Exhaustive sweep of BIN from 0 to 65535 against a reference model -> every BCD digit is <= 9 and the decimal value of BCD equals BIN.
